// File: rtl/framebuffer_writer_pkg.sv
// ----------------------------------------------------------------------------
// framebuffer_writer_pkg
//
// Purpose: shared types for the framebuffer writer and anything that drives it.
//
// Contents:
//   COORD_BITS  - width of one fixed-point coordinate (integer + fraction)
//   coord_2d_t  - packed {x, y} pixel position; x sits in the upper half
// ----------------------------------------------------------------------------
package framebuffer_writer_pkg;

    localparam int COORD_BITS = 16;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } coord_2d_t;

endpackage : framebuffer_writer_pkg

// File: rtl/framebuffer_writer.sv
// ----------------------------------------------------------------------------
// framebuffer_writer
//
// Purpose: accepts a stream of fixed-point pixel positions with colours,
// discards pixels that fall outside the screen, buffers the rest in a small
// FIFO and writes each one to a word-addressed framebuffer memory using a
// request/acknowledge handshake. Counts acknowledged writes and pulses
// frame_done once a full screen's worth has been written.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous, active-low reset
//   vld_in      in   upstream beat valid (always accepted, see rdy_out)
//   color_in    in   pixel colour, COLOR_BITS
//   pixel_in    in   coord_2d_t fixed-point {x, y}
//   rdy_out     out  registered ready; low once only one free entry remains
//   mem_req     out  memory write request
//   mem_addr    out  memory word address, ADDR_BITS
//   mem_wdata   out  memory write data, COLOR_BITS
//   mem_ack     in   memory accepted the current request
//   frame_done  out  one-cycle pulse after the last write of a frame
//   drop_count  out  saturating count of off-screen pixels
//   overflow    out  sticky: an on-screen pixel arrived while the FIFO was full
// ----------------------------------------------------------------------------
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int COLOR_BITS    = 8,
    parameter int FX_TOTAL_BITS = 16,
    parameter int FX_FRAC_BITS  = 8,
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_BITS     = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    input  logic [COLOR_BITS-1:0] color_in,
    input  coord_2d_t             pixel_in,
    output logic                  rdy_out,
    output logic                  mem_req,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [COLOR_BITS-1:0] mem_wdata,
    input  logic                  mem_ack,
    output logic                  frame_done,
    output logic [15:0]           drop_count,
    output logic                  overflow
);

    localparam int PTR_BITS     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS     = PTR_BITS + 1;
    localparam int XI_BITS      = FX_TOTAL_BITS - FX_FRAC_BITS;
    localparam int FRAME_PIXELS = SCREEN_W * SCREEN_H;
    localparam int FRAME_BITS   = $clog2(FRAME_PIXELS);

    localparam logic [CNT_BITS-1:0]   DEPTH_CNT  = CNT_BITS'(FIFO_DEPTH);
    localparam logic [CNT_BITS-1:0]   RDY_LIMIT  = CNT_BITS'(FIFO_DEPTH - 2);
    localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(FRAME_PIXELS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] color;
    } fifo_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q,      state_d;
    logic                    mem_req_q,    mem_req_d;
    logic [ADDR_BITS-1:0]    mem_addr_q,   mem_addr_d;
    logic [COLOR_BITS-1:0]   mem_wdata_q,  mem_wdata_d;

    fifo_entry_t             fifo_mem_q [FIFO_DEPTH];
    fifo_entry_t             fifo_mem_d [FIFO_DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [PTR_BITS-1:0]     rd_ptr_q,     rd_ptr_d;
    logic [CNT_BITS-1:0]     count_q,      count_d;

    logic                    rdy_q,        rdy_d;
    logic                    overflow_q,   overflow_d;
    logic [15:0]             drop_q,       drop_d;
    logic [FRAME_BITS-1:0]   frame_cnt_q,  frame_cnt_d;
    logic                    frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [XI_BITS-1:0]      xi;
    logic [XI_BITS-1:0]      yi;
    logic                    in_bounds;
    logic [ADDR_BITS-1:0]    push_addr;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    fifo_entry_t             head;
    logic                    unused_frac;

    // Integer part of each coordinate; the fraction only positions the
    // pixel inside its cell and has no effect on which word is written.
    always_comb begin
        xi        = pixel_in.x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
        yi        = pixel_in.y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
        in_bounds = (int'(xi) < SCREEN_W) && (int'(yi) < SCREEN_H);
        // Arithmetic at ADDR_BITS width gives the truncated address directly.
        push_addr = ADDR_BITS'(yi) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(xi);
    end

    assign unused_frac = ^{pixel_in.x[FX_FRAC_BITS-1:0], pixel_in.y[FX_FRAC_BITS-1:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign head       = fifo_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Write FSM: IDLE launches the head entry, WRITE holds the request
    // until the memory acknowledges it, then pops and drops the request.
    // mem_ack is only looked at in WRITE, so a stale ack is harmless.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (!fifo_empty) begin
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.color;
                    mem_req_d   = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    pop       = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input side: bounds filtering, FIFO push/pop, drop and overflow
    // bookkeeping, registered ready, and the frame counter.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_d       = drop_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        // A pop on the same edge frees the slot being written, so a full
        // FIFO can still take a beat when the head is leaving.
        push = vld_in && in_bounds && (!fifo_full || pop);

        if (vld_in && !in_bounds && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        if (vld_in && in_bounds && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{addr: push_addr, color: color_in};
            wr_ptr_d             = wr_ptr_q + PTR_BITS'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        // Ready reflects occupancy after this edge; upstream sees it one
        // cycle late, so keep one entry free to absorb that beat.
        rdy_d = (count_d <= RDY_LIMIT);

        if (pop) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset abandons any outstanding write without popping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rdy_q        <= 1'b1;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rdy_q        <= rdy_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rdy_out    = rdy_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_q;
    assign overflow   = overflow_q;

endmodule : framebuffer_writer

// File: tb/tb_framebuffer_writer.sv
// ----------------------------------------------------------------------------
// tb_framebuffer_writer
//
// Purpose: directed bench for framebuffer_writer. Inputs change 1 time unit
// after each rising edge; outputs are checked at that point, and a monitor
// records accepted writes and frame_done pulses on the falling edge.
// ----------------------------------------------------------------------------
module tb_framebuffer_writer;

    import framebuffer_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_in;
    logic [7:0]  color_in;
    coord_2d_t   pixel_in;
    logic        rdy_out;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        frame_done;
    logic [15:0] drop_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    int write_count = 0;
    int wr_addr [$];
    int wr_data [$];
    int done_pulses = 0;
    int done_at = -1;

    framebuffer_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_in     (vld_in),
        .color_in   (color_in),
        .pixel_in   (pixel_in),
        .rdy_out    (rdy_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .frame_done (frame_done),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Falling-edge monitor: a write counts when request and ack are both
    // high for the cycle. frame_done is looked at before this cycle's write.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_pulses++;
            done_at = write_count;
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_wdata));
            write_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] x,
                                 input logic [15:0] y, input logic [7:0] c);
        vld_in     = v;
        pixel_in.x = x;
        pixel_in.y = y;
        color_in   = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int b;

        rst_n   = 1'b0;
        mem_ack = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);

        // Reset values
        tick();
        tick();
        checkOutput("rst_mem_req",    32'(mem_req),    32'd0);
        checkOutput("rst_mem_addr",   32'(mem_addr),   32'd0);
        checkOutput("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
        checkOutput("rst_overflow",   32'(overflow),   32'd0);
        checkOutput("rst_rdy_out",    32'(rdy_out),    32'd1);
        rst_n = 1'b1;
        tick();

        // Single pixel (3,2) -> address 2*160+3 = 323
        $display("[TB] single pixel");
        applyStimulus(1'b1, 16'h0300, 16'h0200, 8'h5A);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
        checkOutput("single_req_not_yet", 32'(mem_req), 32'd0);
        tick();
        checkOutput("single_req_high", 32'(mem_req),   32'd1);
        checkOutput("single_addr",     32'(mem_addr),  32'd323);
        checkOutput("single_wdata",    32'(mem_wdata), 32'h5A);
        tick();
        checkOutput("single_req_held",  32'(mem_req),  32'd1);
        checkOutput("single_addr_held", 32'(mem_addr), 32'd323);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("single_req_fell", 32'(mem_req), 32'd0);
        tick();
        tick();
        tick();
        checkOutput("single_write_count", 32'(write_count), 32'd1);
        checkOutput("single_wr_addr",     32'(wr_addr[0]),  32'd323);
        checkOutput("single_wr_data",     32'(wr_data[0]),  32'h5A);

        // Out-of-bounds pixels: xi=160, then yi=120
        $display("[TB] bounds");
        applyStimulus(1'b1, 16'hA000, 16'h0000, 8'h01);
        tick();
        applyStimulus(1'b1, 16'h0000, 16'h7800, 8'h02);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
        tick();
        tick();
        checkOutput("bounds_drop_count",  32'(drop_count),  32'd2);
        checkOutput("bounds_overflow",    32'(overflow),    32'd0);
        checkOutput("bounds_no_req",      32'(mem_req),     32'd0);
        checkOutput("bounds_write_count", 32'(write_count), 32'd1);

        // Backpressure: ack held low, a beat every cycle
        $display("[TB] backpressure");
        b = write_count;
        applyStimulus(1'b1, 16'h0100, 16'h0000, 8'h11);   // addr 1
        tick();
        applyStimulus(1'b1, 16'h0200, 16'h0100, 8'h22);   // addr 162
        tick();
        checkOutput("bp_rdy_at_2", 32'(rdy_out), 32'd1);
        applyStimulus(1'b1, 16'h9F00, 16'h7700, 8'h33);   // addr 19199 (corner)
        tick();
        checkOutput("bp_rdy_at_3", 32'(rdy_out), 32'd0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h44);   // addr 0
        tick();
        checkOutput("bp_ovf_at_4", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 16'h0500, 16'h0500, 8'h55);   // overflows
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
        checkOutput("bp_overflow",     32'(overflow),   32'd1);
        checkOutput("bp_drop_same",    32'(drop_count), 32'd2);
        checkOutput("bp_req_held",     32'(mem_req),    32'd1);
        tick();
        tick();
        checkOutput("bp_addr_held",  32'(mem_addr),  32'd1);
        checkOutput("bp_wdata_held", 32'(mem_wdata), 32'h11);
        mem_ack = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        mem_ack = 1'b0;
        checkOutput("bp_write_count", 32'(write_count - b), 32'd4);
        checkOutput("bp_w0_addr", 32'(wr_addr[b]),     32'd1);
        checkOutput("bp_w0_data", 32'(wr_data[b]),     32'h11);
        checkOutput("bp_w1_addr", 32'(wr_addr[b + 1]), 32'd162);
        checkOutput("bp_w1_data", 32'(wr_data[b + 1]), 32'h22);
        checkOutput("bp_w2_addr", 32'(wr_addr[b + 2]), 32'd19199);
        checkOutput("bp_w2_data", 32'(wr_data[b + 2]), 32'h33);
        checkOutput("bp_w3_addr", 32'(wr_addr[b + 3]), 32'd0);
        checkOutput("bp_w3_data", 32'(wr_data[b + 3]), 32'h44);
        checkOutput("bp_rdy_back", 32'(rdy_out), 32'd1);
        checkOutput("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Reset while a write is outstanding
        $display("[TB] reset mid-write");
        b = write_count;
        applyStimulus(1'b1, 16'h0700, 16'h0000, 8'h77);
        tick();
        applyStimulus(1'b1, 16'h0800, 16'h0000, 8'h88);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
        checkOutput("rmw_in_write", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        checkOutput("rmw_req_low",  32'(mem_req),    32'd0);
        checkOutput("rmw_rdy",      32'(rdy_out),    32'd1);
        checkOutput("rmw_ovf_clr",  32'(overflow),   32'd0);
        checkOutput("rmw_drop_clr", 32'(drop_count), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        mem_ack = 1'b0;
        checkOutput("rmw_still_idle",  32'(mem_req),         32'd0);
        checkOutput("rmw_no_writes",   32'(write_count - b), 32'd0);

        // Full FIFO with a push and pop on the same edge
        $display("[TB] full push+pop");
        b = write_count;
        applyStimulus(1'b1, 16'h0A00, 16'h0000, 8'hC0);
        tick();
        applyStimulus(1'b1, 16'h0B00, 16'h0000, 8'hC1);
        tick();
        applyStimulus(1'b1, 16'h0C00, 16'h0000, 8'hC2);
        tick();
        applyStimulus(1'b1, 16'h0D00, 16'h0000, 8'hC3);
        tick();
        checkOutput("pp_rdy_full", 32'(rdy_out),  32'd0);
        checkOutput("pp_head",     32'(mem_addr), 32'd10);
        applyStimulus(1'b1, 16'h0E00, 16'h0000, 8'hC4);
        mem_ack = 1'b1;
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
        checkOutput("pp_no_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        mem_ack = 1'b0;
        checkOutput("pp_write_count", 32'(write_count - b), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("pp_w%0d_addr", k), 32'(wr_addr[b + k]), 32'(10 + k));
            checkOutput($sformatf("pp_w%0d_data", k), 32'(wr_data[b + k]), 32'(8'hC0 + k));
        end
        checkOutput("pp_ovf_end", 32'(overflow), 32'd0);

        // Full frame of 19200 pixels with ack tied high
        $display("[TB] frame");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        b = write_count;
        mem_ack = 1'b1;
        checkOutput("frame_no_pulse_yet", 32'(done_pulses), 32'd0);
        for (int i = 0; i < 19200; i++) begin
            applyStimulus(1'b1, 16'((i % 160) << 8), 16'((i / 160) << 8), 8'(i));
            tick();
            applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h00);
            tick();
        end
        for (int i = 0; i < 8; i++) tick();
        mem_ack = 1'b0;
        checkOutput("frame_writes",    32'(write_count - b), 32'd19200);
        checkOutput("frame_pulses",    32'(done_pulses),     32'd1);
        checkOutput("frame_pulse_at",  32'(done_at - b),     32'd19200);
        checkOutput("frame_last_addr", 32'(wr_addr[write_count - 1]), 32'd19199);
        checkOutput("frame_overflow",  32'(overflow),        32'd0);
        checkOutput("frame_drops",     32'(drop_count),      32'd0);
        checkOutput("frame_done_low",  32'(frame_done),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_framebuffer_writer
